// File: rtl/parc_mem_arb.sv
//------------------------------------------------------------------------------
// parc_mem_arb
//
// Merges the PARCv2 core's instruction-memory port (port 0) and data-memory
// port (port 1) onto one shared memory port. Requests are arbitrated
// round-robin. A small tag FIFO remembers which port issued each outstanding
// request so that in-order memory responses can be steered back to their
// issuer. Both the request and the response paths are purely combinational,
// so the arbiter adds no latency.
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   req0_msg/val/rdy      port 0 (imem) request  {type, addr, len, data}
//   resp0_msg/val         port 0 (imem) response {type, len, data}
//   req1_msg/val/rdy      port 1 (dmem) request
//   resp1_msg/val         port 1 (dmem) response
//   memreq_msg/val/rdy    shared request toward memory
//   memresp_msg/val       shared response from memory (no backpressure)
//------------------------------------------------------------------------------
module parc_mem_arb #(
    parameter int p_addr_sz  = 32,
    parameter int p_data_sz  = 32,
    parameter int p_max_outs = 4,
    localparam int c_lenSz   = $clog2(p_data_sz / 8),
    localparam int c_reqSz   = 1 + p_addr_sz + c_lenSz + p_data_sz,
    localparam int c_respSz  = 1 + c_lenSz + p_data_sz,
    localparam int c_ptrSz   = $clog2(p_max_outs)
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [c_reqSz-1:0]  req0_msg,
    input  logic                req0_val,
    output logic                req0_rdy,
    output logic [c_respSz-1:0] resp0_msg,
    output logic                resp0_val,

    input  logic [c_reqSz-1:0]  req1_msg,
    input  logic                req1_val,
    output logic                req1_rdy,
    output logic [c_respSz-1:0] resp1_msg,
    output logic                resp1_val,

    output logic [c_reqSz-1:0]  memreq_msg,
    output logic                memreq_val,
    input  logic                memreq_rdy,
    input  logic [c_respSz-1:0] memresp_msg,
    input  logic                memresp_val
);

    localparam logic [c_ptrSz:0] c_depth = (c_ptrSz + 1)'(p_max_outs);

    // Tag FIFO storage: one bit per outstanding request, holding the index of
    // the port that issued it.
    logic [p_max_outs-1:0] r_tags;
    logic [c_ptrSz-1:0]    r_wrPtr;
    logic [c_ptrSz-1:0]    r_rdPtr;
    logic [c_ptrSz:0]      r_count;
    logic                  r_lastGrant;

    logic w_full;
    logic w_empty;
    logic w_anyVal;
    logic w_grantIdx;
    logic w_grant0;
    logic w_grant1;
    logic w_reqOk;
    logic w_push;
    logic w_pop;
    logic w_headTag;

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // Round-robin grant. When both ports want the memory, the one that did
    // not win last time goes next; a lone requester always wins. With no
    // requester the index defaults to port 0 so memreq_msg mirrors req0_msg.
    always_comb begin
        w_grantIdx = 1'b0;
        if (req0_val && req1_val) begin
            w_grantIdx = ~r_lastGrant;
        end else if (req1_val) begin
            w_grantIdx = 1'b1;
        end
    end

    assign w_anyVal = req0_val | req1_val;
    assign w_grant0 = req0_val & ~w_grantIdx;
    assign w_grant1 = req1_val &  w_grantIdx;

    // A full FIFO blocks every grant even if a pop happens this cycle, which
    // keeps memreq_val independent of memreq_rdy and memresp_val.
    assign w_reqOk    = ~w_full & ~reset;
    assign memreq_val = w_anyVal & w_reqOk;
    assign memreq_msg = w_grantIdx ? req1_msg : req0_msg;
    assign req0_rdy   = w_grant0 & memreq_rdy & w_reqOk;
    assign req1_rdy   = w_grant1 & memreq_rdy & w_reqOk;

    assign w_push = memreq_val & memreq_rdy;

    // A response arriving with nothing outstanding is a protocol error; it
    // is simply dropped and does not disturb the FIFO.
    assign w_pop     = memresp_val & ~w_empty;
    assign w_headTag = r_tags[r_rdPtr];

    assign resp0_val = w_pop & ~w_headTag & ~reset;
    assign resp1_val = w_pop &  w_headTag & ~reset;
    assign resp0_msg = memresp_msg;
    assign resp1_msg = memresp_msg;

    // Tag storage needs no reset: an entry is only read after it has been
    // written since the pointers were last cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tags[r_wrPtr] <= w_grantIdx;
        end
    end

    // Pointers wrap naturally because the depth is a power of two. Pushing
    // and popping together advances both pointers and leaves the count alone.
    // last_grant resets to port 1 so that port 0 wins the first contest.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_lastGrant <= 1'b1;
        end else begin
            if (w_push) begin
                r_wrPtr     <= r_wrPtr + 1'b1;
                r_lastGrant <= w_grantIdx;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_parc_mem_arb.sv
//------------------------------------------------------------------------------
// tb_parc_mem_arb
//
// Directed bench for parc_mem_arb. A queue-based model of the outstanding
// requests predicts every DUT output each cycle; a simple in-order memory
// answers accepted requests one cycle later unless told to hold off.
//------------------------------------------------------------------------------
module tb_parc_mem_arb;

    localparam int REQ_SZ  = 67;
    localparam int RESP_SZ = 35;
    localparam int MAXO    = 4;

    logic               clk;
    logic               reset;
    logic [REQ_SZ-1:0]  req0_msg, req1_msg, memreq_msg;
    logic               req0_val, req1_val, req0_rdy, req1_rdy;
    logic [RESP_SZ-1:0] resp0_msg, resp1_msg, memresp_msg;
    logic               resp0_val, resp1_val;
    logic               memreq_val, memreq_rdy, memresp_val;

    int total = 0;
    int bad   = 0;

    parc_mem_arb #(
        .p_addr_sz  (32),
        .p_data_sz  (32),
        .p_max_outs (MAXO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_msg    (req0_msg),
        .req0_val    (req0_val),
        .req0_rdy    (req0_rdy),
        .resp0_msg   (resp0_msg),
        .resp0_val   (resp0_val),
        .req1_msg    (req1_msg),
        .req1_val    (req1_val),
        .req1_rdy    (req1_rdy),
        .resp1_msg   (resp1_msg),
        .resp1_val   (resp1_val),
        .memreq_msg  (memreq_msg),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memresp_msg (memresp_msg),
        .memresp_val (memresp_val)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [REQ_SZ-1:0] mkReq(input logic [31:0] addr);
        return {1'b0, addr, 2'b00, ~addr};
    endfunction

    task automatic checkOutput(input string name, input logic [REQ_SZ-1:0] act,
                               input logic [REQ_SZ-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // In-order memory: accepted requests queue up and the head is answered
    // from the next cycle on, unless memHold is set. Responses echo the
    // request address in the data field.
    logic              memHold;
    logic [REQ_SZ-1:0] memQ[$];

    initial begin
        memresp_val = 1'b0;
        memresp_msg = '0;
        forever begin
            @(posedge clk);
            if (memresp_val) void'(memQ.pop_front());
            if (memreq_val && memreq_rdy) memQ.push_back(memreq_msg);
            #2;
            if (!memHold && memQ.size() > 0) begin
                memresp_val = 1'b1;
                memresp_msg = {memQ[0][66], memQ[0][33:32], memQ[0][65:34]};
            end else begin
                memresp_val = 1'b0;
                memresp_msg = '0;
            end
        end
    end

    // Model: a queue of issuing-port indices for outstanding requests, and the
    // port that won most recently.
    bit mq[$];
    bit mLast = 1'b1;
    int maxCount = 0;
    bit checking = 1'b0;

    function automatic bit modelGrant();
        if (req0_val && req1_val) return !mLast;
        return req1_val && !req0_val;
    endfunction

    initial begin
        bit g;
        bit fire;
        bit pop;
        forever begin
            @(posedge clk);
            if (reset) begin
                mq.delete();
                mLast = 1'b1;
            end else begin
                g    = modelGrant();
                fire = (req0_val || req1_val) && (mq.size() < MAXO) && memreq_rdy;
                pop  = memresp_val && (mq.size() > 0);
                if (pop) void'(mq.pop_front());
                if (fire) begin
                    mq.push_back(g);
                    mLast = g;
                end
                if (mq.size() > maxCount) maxCount = mq.size();
            end
        end
    end

    // Compare process: every cycle on the falling edge.
    initial begin
        bit g, anyV, full, empty, head, eVal;
        forever begin
            @(negedge clk);
            if (checking) begin
                g     = modelGrant();
                anyV  = req0_val || req1_val;
                full  = (mq.size() == MAXO);
                empty = (mq.size() == 0);
                head  = empty ? 1'b0 : mq[0];
                eVal  = anyV && !full && !reset;
                checkOutput("memreq_val", memreq_val, eVal);
                checkOutput("memreq_msg", memreq_msg, g ? req1_msg : req0_msg);
                checkOutput("req0_rdy", req0_rdy, eVal && !g && memreq_rdy);
                checkOutput("req1_rdy", req1_rdy, eVal && g && memreq_rdy);
                checkOutput("resp0_val", resp0_val, memresp_val && !empty && !head && !reset);
                checkOutput("resp1_val", resp1_val, memresp_val && !empty && head && !reset);
                checkOutput("resp0_msg", resp0_msg, memresp_msg);
                checkOutput("resp1_msg", resp1_msg, memresp_msg);
            end
        end
    end

    // One cycle of stimulus: inputs change just after the rising edge and the
    // caller may inspect outputs once they have settled (posedge + 3).
    task automatic applyStimulus(input logic rst, input logic v0, input logic [31:0] a0,
                                 input logic v1, input logic [31:0] a1,
                                 input logic rdy, input logic hold);
        @(posedge clk);
        #1;
        reset      = rst;
        req0_val   = v0;
        req0_msg   = mkReq(a0);
        req1_val   = v1;
        req1_msg   = mkReq(a1);
        memreq_rdy = rdy;
        memHold    = hold;
        #2;
    endtask

    logic [15:0] p0, p1, pr, ph;

    initial begin
        reset      = 1'b1;
        req0_val   = 1'b0;
        req1_val   = 1'b0;
        req0_msg   = '0;
        req1_msg   = '0;
        memreq_rdy = 1'b0;
        memHold    = 1'b0;

        applyStimulus(1, 0, 0, 0, 0, 1, 0);
        checking = 1'b1;
        applyStimulus(1, 1, 32'h10, 1, 32'h20, 1, 0);
        checkOutput("reset_memreq_val", memreq_val, 0);
        checkOutput("reset_req0_rdy", req0_rdy, 0);
        checkOutput("reset_req1_rdy", req1_rdy, 0);

        // Both ports always valid: strict alternation starting at port 0,
        // responses return on the issuer one cycle later.
        $display("[TB] dual-request alternation");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, 32'h1000_0000 + k, 1, 32'h2000_0000 + k, 1, 0);
            checkOutput("alt_addr", memreq_msg[65:34],
                        (k % 2 == 0) ? 32'h1000_0000 + k : 32'h2000_0000 + k);
            checkOutput("alt_req0_rdy", req0_rdy, (k % 2 == 0));
            if (k > 0) begin
                checkOutput("alt_resp0_val", resp0_val, ((k - 1) % 2 == 0));
                checkOutput("alt_resp1_val", resp1_val, ((k - 1) % 2 == 1));
            end
        end

        // Port 1 alone, then a contest that port 0 must win.
        $display("[TB] port 1 alone then contest");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 0, 1, 32'h3000_0000 + k, 1, 0);
            checkOutput("solo1_req1_rdy", req1_rdy, 1);
        end
        applyStimulus(0, 1, 32'h3100_0000, 1, 32'h3200_0000, 1, 0);
        checkOutput("contest_req0_rdy", req0_rdy, 1);
        checkOutput("contest_req1_rdy", req1_rdy, 0);

        // Memory not ready: request held stable until rdy rises.
        $display("[TB] memory backpressure");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 32'h4000_0000, 0, 0, 0, 0);
            checkOutput("bp_req0_rdy", req0_rdy, 0);
            checkOutput("bp_memreq_val", memreq_val, 1);
            checkOutput("bp_addr", memreq_msg[65:34], 32'h4000_0000);
        end
        applyStimulus(0, 1, 32'h4000_0000, 0, 0, 1, 0);
        checkOutput("bp_fire", req0_rdy, 1);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 1, 0);

        // Fill the tag FIFO while memory withholds responses.
        $display("[TB] full FIFO");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 32'h4100_0000 + k, 0, 0, 1, 1);
            checkOutput("fill_req0_rdy", req0_rdy, 1);
        end
        applyStimulus(0, 1, 32'h4100_0004, 0, 0, 1, 1);
        checkOutput("full_memreq_val", memreq_val, 0);
        checkOutput("full_model_count", mq.size(), 4);
        applyStimulus(0, 1, 32'h4100_0004, 0, 0, 1, 0);
        checkOutput("full_pop_memreq_val", memreq_val, 0);
        checkOutput("full_pop_resp0_val", resp0_val, 1);
        applyStimulus(0, 1, 32'h4100_0004, 0, 0, 1, 1);
        checkOutput("after_pop_memreq_val", memreq_val, 1);
        checkOutput("after_pop_req0_rdy", req0_rdy, 1);
        checkOutput("model_max_count", maxCount, 4);
        for (int k = 0; k < 6; k++) applyStimulus(0, 0, 0, 0, 0, 1, 0);

        // Mixed traffic with pushes and pops across pointer wrap.
        $display("[TB] mixed traffic");
        p0 = 16'b1011_0111_1101_1011;
        p1 = 16'b1110_1101_0111_0110;
        pr = 16'b1111_1011_1111_1101;
        ph = 16'b0001_1100_0111_0000;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, p0[k], 32'h5000_0000 + k, p1[k], 32'h6000_0000 + k, pr[k], ph[k]);
        end
        for (int k = 0; k < 6; k++) applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("mixed_max_count", maxCount, 4);

        // Reset with three requests outstanding; their late responses are
        // dropped and the next request routes normally.
        $display("[TB] reset with outstanding requests");
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 32'h7000_0000 + k, 1, 32'h7100_0000 + k, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0);
            checkOutput("stray_resp0_val", resp0_val, 0);
            checkOutput("stray_resp1_val", resp1_val, 0);
            checkOutput("stray_model_count", mq.size(), 0);
        end
        applyStimulus(0, 0, 0, 1, 32'h7200_0000, 1, 0);
        checkOutput("post_reset_req1_rdy", req1_rdy, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("post_reset_resp1_val", resp1_val, 1);
        checkOutput("post_reset_resp0_val", resp0_val, 0);
        checkOutput("post_reset_resp_addr", resp1_msg[31:0], 32'h7200_0000);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);

        @(posedge clk);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
